alu_issue_ctrl: RTL and testbench

Issue/collect controller on the driving side of the ALU's operand/control interface. Accepts an operation request (ALUOp, funct, two operands) over a valid/ready handshake and decodes it into the 3-bit ALU control code. It drives registered operands and the code to the combinational ALU, holding them stable for a multicycle window on multiply. It then captures the ALU result and Zero flag and returns them over a second valid/ready handshake.

---
 rtl/alu_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_alu_issue_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_ctrl.sv
// Issue/collect controller for the combinational ALU: decodes a request into an
// ALU control code, holds operands for a multicycle window, and returns the result.
module alu_issue_ctrl #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  ALUOp_i,
  input  logic [5:0]  funct_i,
  input  logic [31:0] data1_i,
  input  logic [31:0] data2_i,
  output logic [2:0]  ALUCtrl_o,
  output logic [31:0] alu_data1_o,
  output logic [31:0] alu_data2_o,
  input  logic [31:0] alu_data_i,
  input  logic        alu_Zero_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [31:0] data_o,
  output logic        Zero_o,
  output logic        illegal_o
);

  localparam logic [2:0]       CODE_AND = 3'b000;
  localparam logic [2:0]       CODE_OR  = 3'b001;
  localparam logic [2:0]       CODE_ADD = 3'b010;
  localparam logic [2:0]       CODE_SUB = 3'b011;
  localparam logic [2:0]       CODE_MUL = 3'b100;
  localparam logic [CNT_W-1:0] MUL_CNT  = CNT_W'(MUL_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       dec_code;
  logic             dec_illegal;
  logic             illegal_pend;
  logic             accept;
  logic             capture;

  assign accept  = (state == IDLE) && valid_i;
  assign capture = (state == EXEC) && (cnt == '0);

  // Request decode; anything unrecognised falls back to add and is flagged.
  always_comb begin
    dec_code    = CODE_ADD;
    dec_illegal = 1'b0;
    case (ALUOp_i)
      2'b00: dec_code = CODE_ADD;
      2'b01: dec_code = CODE_SUB;
      2'b10: begin
        case (funct_i)
          6'b100100: dec_code = CODE_AND;
          6'b100101: dec_code = CODE_OR;
          6'b100000: dec_code = CODE_ADD;
          6'b100010: dec_code = CODE_SUB;
          6'b011000: dec_code = CODE_MUL;
          default:   dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (valid_i) begin
          state_next = EXEC;
          cnt_next   = (dec_code == CODE_MUL) ? MUL_CNT : '0;
        end
      end
      EXEC: begin
        if (cnt == '0) state_next = RESP;
        else           cnt_next   = cnt - CNT_W'(1);
      end
      RESP: begin
        if (ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ALU-side operands/code only change on accept, so they are stable through EXEC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_o      <= 1'b1;
      valid_o      <= 1'b0;
      ALUCtrl_o    <= CODE_AND;
      alu_data1_o  <= '0;
      alu_data2_o  <= '0;
      illegal_pend <= 1'b0;
      data_o       <= '0;
      Zero_o       <= 1'b0;
      illegal_o    <= 1'b0;
    end else begin
      ready_o <= (state_next == IDLE);
      valid_o <= (state_next == RESP);
      if (accept) begin
        ALUCtrl_o    <= dec_code;
        alu_data1_o  <= data1_i;
        alu_data2_o  <= data2_i;
        illegal_pend <= dec_illegal;
      end
      if (capture) begin
        data_o    <= alu_data_i;
        Zero_o    <= alu_Zero_i;
        illegal_o <= illegal_pend;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed and random requests against a reference model,
// with a behavioural ALU closing the loop on the ALU-side ports.
module tb_alu_issue_ctrl;

  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned CNT_W   = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  ALUOp_i;
  logic [5:0]  funct_i;
  logic [31:0] data1_i, data2_i;
  logic [2:0]  ALUCtrl_o;
  logic [31:0] alu_data1_o, alu_data2_o;
  logic [31:0] alu_data_i;
  logic        alu_Zero_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic        Zero_o;
  logic        illegal_o;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .ALUOp_i(ALUOp_i), .funct_i(funct_i), .data1_i(data1_i), .data2_i(data2_i),
    .ALUCtrl_o(ALUCtrl_o), .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o),
    .alu_data_i(alu_data_i), .alu_Zero_i(alu_Zero_i), .valid_o(valid_o),
    .ready_i(ready_i), .data_o(data_o), .Zero_o(Zero_o), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  // Combinational ALU seen by the controller.
  always_comb begin
    case (ALUCtrl_o)
      3'b000:  alu_data_i = alu_data1_o & alu_data2_o;
      3'b001:  alu_data_i = alu_data1_o | alu_data2_o;
      3'b010:  alu_data_i = alu_data1_o + alu_data2_o;
      3'b011:  alu_data_i = alu_data1_o - alu_data2_o;
      3'b100:  alu_data_i = alu_data1_o * alu_data2_o;
      default: alu_data_i = 32'hdead_beef;
    endcase
  end
  assign alu_Zero_i = (alu_data_i == 32'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: what the request means, independent of how the controller stores it.
  task automatic ref_model(input logic [1:0] op, input logic [5:0] fn,
                           input logic [31:0] a, input logic [31:0] b,
                           output logic [2:0] code, output logic ill,
                           output logic [31:0] res, output int lat);
    ill = 1'b0;
    code = 3'b010;
    res = a + b;
    if (op == 2'b01) begin
      code = 3'b011; res = a - b;
    end else if (op == 2'b10) begin
      if      (fn == 6'h24) begin code = 3'b000; res = a & b; end
      else if (fn == 6'h25) begin code = 3'b001; res = a | b; end
      else if (fn == 6'h20) begin code = 3'b010; res = a + b; end
      else if (fn == 6'h22) begin code = 3'b011; res = a - b; end
      else if (fn == 6'h18) begin code = 3'b100; res = 32'(64'(a) * 64'(b)); end
      else ill = 1'b1;
    end else if (op == 2'b11) begin
      ill = 1'b1;
    end
    lat = (code == 3'b100) ? int'(MUL_LAT) : 1;
  endtask

  // One transaction: accept, watch EXEC hold, check latency/result, apply backpressure.
  task automatic do_op(input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input int bp);
    logic [2:0]  e_code;
    logic        e_ill;
    logic [31:0] e_res;
    int          e_lat;
    int          edges;
    ref_model(op, fn, a, b, e_code, e_ill, e_res, e_lat);
    chk("ready_before_accept", 32'(ready_o), 32'd1);
    ALUOp_i = op; funct_i = fn; data1_i = a; data2_i = b;
    valid_i = 1'b1;
    ready_i = (bp == 0);
    @(posedge clk_i); @(negedge clk_i);
    valid_i = 1'b0;
    data1_i = $urandom; data2_i = $urandom;
    edges = 0;
    while (!valid_o && edges < 40) begin
      chk("exec_code", 32'(ALUCtrl_o), 32'(e_code));
      chk("exec_data1", alu_data1_o, a);
      chk("exec_data2", alu_data2_o, b);
      chk("exec_ready_low", 32'(ready_o), 32'd0);
      @(posedge clk_i); @(negedge clk_i);
      edges++;
    end
    chk("latency", 32'(edges), 32'(e_lat));
    chk("resp_data", data_o, e_res);
    chk("resp_zero", 32'(Zero_o), 32'(e_res == 32'd0));
    chk("resp_illegal", 32'(illegal_o), 32'(e_ill));
    for (int i = 0; i < bp; i++) begin
      ready_i = 1'b0;
      valid_i = 1'b1;
      ALUOp_i = 2'b01; data1_i = ~a; data2_i = $urandom;
      @(posedge clk_i); @(negedge clk_i);
      chk("bp_valid_held", 32'(valid_o), 32'd1);
      chk("bp_data_held", data_o, e_res);
      chk("bp_illegal_held", 32'(illegal_o), 32'(e_ill));
      chk("bp_ready_low", 32'(ready_o), 32'd0);
    end
    ready_i = 1'b1;
    valid_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    chk("post_valid_low", 32'(valid_o), 32'd0);
    chk("post_ready_high", 32'(ready_o), 32'd1);
    chk("no_spurious_accept", alu_data1_o, a);
  endtask

  logic [5:0] fn_pool [7] = '{6'h24, 6'h25, 6'h20, 6'h22, 6'h18, 6'h3f, 6'h00};

  initial begin
    rst_i = 1'b1; valid_i = 1'b1; ready_i = 1'b0;
    ALUOp_i = 2'b00; funct_i = 6'h00; data1_i = 32'd11; data2_i = 32'd22;

    // Reset held for two cycles with a pending request.
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_i); @(negedge clk_i);
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_code", 32'(ALUCtrl_o), 32'd0);
      chk("rst_data", data_o, 32'd0);
      chk("rst_alu_data1", alu_data1_o, 32'd0);
      chk("rst_illegal", 32'(illegal_o), 32'd0);
    end
    rst_i = 1'b0; valid_i = 1'b0;
    @(posedge clk_i); @(negedge clk_i);
    chk("after_rst_idle", 32'(ready_o), 32'd1);

    // Directed cases.
    do_op(2'b10, 6'b100000, 32'd5, 32'd7, 0);
    do_op(2'b01, 6'h00, 32'd9, 32'd9, 0);
    do_op(2'b10, 6'b011000, 32'h0001_0000, 32'h0001_0000, 0);
    do_op(2'b10, 6'b111111, 32'd3, 32'd4, 3);
    do_op(2'b11, 6'h20, 32'hffff_ffff, 32'd1, 1);
    do_op(2'b10, 6'b100100, 32'hf0f0_1234, 32'h0ff0_ffff, 0);
    do_op(2'b10, 6'b100101, 32'h0000_00f0, 32'h0000_0f00, 2);

    // Random requests.
    for (int n = 0; n < 30; n++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      do_op(2'($urandom_range(0, 3)), fn_pool[$urandom_range(0, 6)], a, b,
            int'($urandom_range(0, 2)));
    end

    // Reset during the second EXEC cycle of a multiply drops the transaction.
    ALUOp_i = 2'b10; funct_i = 6'b011000; data1_i = 32'd6; data2_i = 32'd7;
    valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    valid_i = 1'b0;
    chk("midrst_exec_ready_low", 32'(ready_o), 32'd0);
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i); @(negedge clk_i);
    rst_i = 1'b0;
    chk("midrst_ready", 32'(ready_o), 32'd1);
    chk("midrst_valid", 32'(valid_o), 32'd0);
    begin
      int seen = 0;
      for (int i = 0; i < 8; i++) begin
        @(posedge clk_i); @(negedge clk_i);
        if (valid_o) seen++;
      end
      chk("midrst_no_response", 32'(seen), 32'd0);
    end
    do_op(2'b00, 6'h00, 32'd100, 32'd23, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
